// File: rtl/nk_game_engine_if.sv
// Move-request handshake between a player front-end and nk_game_engine.
interface nk_game_engine_if #(
  parameter int CW = 2
);
  logic          move_valid;
  logic [CW-1:0] move_row;
  logic [CW-1:0] move_col;
  logic          move_ready;

  modport master (output move_valid, move_row, move_col, input move_ready);
  modport slave  (input move_valid, move_row, move_col, output move_ready);
endinterface

// File: rtl/nk_game_engine.sv
// N x N, K-in-a-row two-player board engine: move handshake, sequential win
// scan around the last stone, persistent scores and 7-segment result display.
module nk_game_engine #(
  parameter int  N       = 3,
  parameter int  K       = 3,
  parameter int  SCORE_W = 4,
  localparam int CW      = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int CELLS   = N * N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  nk_game_engine_if.slave      mv,
  output logic                 illegal,
  output logic                 busy,
  output logic [1:0]           current_player,
  output logic [2*CELLS-1:0]   board,
  output logic [CELLS-1:0]     leds,
  output logic [1:0]           winner,
  output logic                 draw,
  output logic                 game_over,
  output logic [SCORE_W-1:0]   score1,
  output logic [SCORE_W-1:0]   score2,
  output logic [6:0]           win1,
  output logic [6:0]           win2
);

  localparam int IW = $clog2(CELLS);
  localparam int MW = $clog2(CELLS + 1);
  localparam int RW = $clog2(K + 1);
  localparam int PW = CW + 2;
  localparam logic signed [PW-1:0] NS = PW'(N);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ONE   = 7'b1001111;
  localparam logic [6:0] SEG_TWO   = 7'b0010010;
  localparam logic [6:0] SEG_D     = 7'b1000010;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t                 state_q, state_n;
  logic [2*CELLS-1:0]     board_q, board_n;
  logic [MW-1:0]          move_cnt_q, move_cnt_n;
  logic [1:0]             player_q, player_n;
  logic [1:0]             starter_q, starter_n;
  logic [1:0]             winner_q, winner_n;
  logic                   draw_q, draw_n;
  logic [SCORE_W-1:0]     score1_q, score1_n, score2_q, score2_n;
  logic [6:0]             win1_q, win1_n, win2_q, win2_n;
  logic                   illegal_q, illegal_n;
  logic [1:0]             dir_q, dir_n;
  logic                   back_q, back_n;
  logic signed [PW-1:0]   pos_r_q, pos_r_n, pos_c_q, pos_c_n;
  logic [CW-1:0]          org_r_q, org_r_n, org_c_q, org_c_n;
  logic [RW-1:0]          run_q, run_n;

  logic                   req_inb, req_free;
  logic [IW-1:0]          req_idx, nxt_idx;
  logic signed [PW-1:0]   dr, dc, nr, nc;
  logic                   nxt_inb, nxt_match;
  logic [RW-1:0]          run_inc;
  logic                   accept, win_hit, scan_done;

  assign game_over      = (winner_q != 2'b00) | draw_q;
  assign mv.move_ready  = (state_q == IDLE) && !game_over;
  assign busy           = (state_q == CHECK);
  assign illegal        = illegal_q;
  assign current_player = player_q;
  assign board          = board_q;
  assign winner         = winner_q;
  assign draw           = draw_q;
  assign score1         = score1_q;
  assign score2         = score2_q;
  assign win1           = win1_q;
  assign win2           = win2_q;

  always_comb begin
    leds = '0;
    for (int unsigned i = 0; i < CELLS; i++) leds[i] = |board_q[2*i +: 2];
  end

  // Requested cell lookup and the one-cell-per-cycle walk probe.
  always_comb begin
    req_inb  = ({1'b0, mv.move_row} < (CW+1)'(N)) && ({1'b0, mv.move_col} < (CW+1)'(N));
    req_idx  = IW'(mv.move_row) * IW'(N) + IW'(mv.move_col);
    req_free = req_inb && (board_q[2*req_idx +: 2] == 2'b00);

    dr = '0;
    dc = '0;
    unique case (dir_q)
      2'd0:    dc = PW'(1);
      2'd1:    dr = PW'(1);
      2'd2:    begin dr = PW'(1); dc = PW'(1); end
      default: begin dr = PW'(1); dc = '1;     end
    endcase
    if (back_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr        = pos_r_q + dr;
    nc        = pos_c_q + dc;
    nxt_inb   = !nr[PW-1] && (nr < NS) && !nc[PW-1] && (nc < NS);
    nxt_idx   = IW'(nr[CW-1:0]) * IW'(N) + IW'(nc[CW-1:0]);
    nxt_match = nxt_inb && (board_q[2*nxt_idx +: 2] == player_q);
    run_inc   = run_q + 1'b1;
  end

  always_comb begin
    state_n    = state_q;
    board_n    = board_q;
    move_cnt_n = move_cnt_q;
    player_n   = player_q;
    starter_n  = starter_q;
    winner_n   = winner_q;
    draw_n     = draw_q;
    score1_n   = score1_q;
    score2_n   = score2_q;
    win1_n     = win1_q;
    win2_n     = win2_q;
    illegal_n  = 1'b0;
    dir_n      = dir_q;
    back_n     = back_q;
    pos_r_n    = pos_r_q;
    pos_c_n    = pos_c_q;
    org_r_n    = org_r_q;
    org_c_n    = org_c_q;
    run_n      = run_q;
    accept     = mv.move_valid && mv.move_ready;
    win_hit    = 1'b0;
    scan_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && req_free) begin
          board_n[2*req_idx +: 2] = player_q;
          move_cnt_n = move_cnt_q + 1'b1;
          dir_n      = 2'd0;
          back_n     = 1'b0;
          pos_r_n    = PW'(mv.move_row);
          pos_c_n    = PW'(mv.move_col);
          org_r_n    = mv.move_row;
          org_c_n    = mv.move_col;
          run_n      = RW'(1);
          state_n    = CHECK;
        end else if (accept) begin
          illegal_n = 1'b1;
        end
      end
      CHECK: begin
        // A failed probe ends the forward walk, then the backward walk, then the direction.
        if (nxt_match) begin
          run_n   = run_inc;
          pos_r_n = nr;
          pos_c_n = nc;
          if (run_inc >= RW'(K)) win_hit = 1'b1;
        end else if (!back_q) begin
          back_n  = 1'b1;
          pos_r_n = PW'(org_r_q);
          pos_c_n = PW'(org_c_q);
        end else if (dir_q != 2'd3) begin
          dir_n   = dir_q + 1'b1;
          back_n  = 1'b0;
          pos_r_n = PW'(org_r_q);
          pos_c_n = PW'(org_c_q);
          run_n   = RW'(1);
        end else begin
          scan_done = 1'b1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase

    if (win_hit) begin
      winner_n = player_q;
      state_n  = DONE;
      if (player_q == 2'b01) begin
        if (score1_q != '1) score1_n = score1_q + 1'b1;
        win1_n = SEG_ONE;
      end else begin
        if (score2_q != '1) score2_n = score2_q + 1'b1;
        win2_n = SEG_TWO;
      end
    end else if (scan_done) begin
      if (move_cnt_q == MW'(CELLS)) begin
        draw_n  = 1'b1;
        win1_n  = SEG_D;
        state_n = DONE;
      end else begin
        player_n = ~player_q;
        state_n  = IDLE;
      end
    end

    if (new_game) begin
      state_n    = IDLE;
      board_n    = '0;
      move_cnt_n = '0;
      player_n   = starter_q;
      starter_n  = ~starter_q;
      winner_n   = 2'b00;
      draw_n     = 1'b0;
      win1_n     = SEG_BLANK;
      win2_n     = SEG_BLANK;
      illegal_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      board_q    <= '0;
      move_cnt_q <= '0;
      player_q   <= 2'b01;
      starter_q  <= 2'b10;
      winner_q   <= 2'b00;
      draw_q     <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      win1_q     <= SEG_BLANK;
      win2_q     <= SEG_BLANK;
      illegal_q  <= 1'b0;
      dir_q      <= '0;
      back_q     <= 1'b0;
      pos_r_q    <= '0;
      pos_c_q    <= '0;
      org_r_q    <= '0;
      org_c_q    <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_n;
      board_q    <= board_n;
      move_cnt_q <= move_cnt_n;
      player_q   <= player_n;
      starter_q  <= starter_n;
      winner_q   <= winner_n;
      draw_q     <= draw_n;
      score1_q   <= score1_n;
      score2_q   <= score2_n;
      win1_q     <= win1_n;
      win2_q     <= win2_n;
      illegal_q  <= illegal_n;
      dir_q      <= dir_n;
      back_q     <= back_n;
      pos_r_q    <= pos_r_n;
      pos_c_q    <= pos_c_n;
      org_r_q    <= org_r_n;
      org_c_q    <= org_c_n;
      run_q      <= run_n;
    end
  end

endmodule

// File: tb/tb_nk_game_engine.sv
// Bench for nk_game_engine: a 3x3/K=3 engine and a 5x5/K=4/SCORE_W=1 engine
// driven by directed and random games against a board-level reference model.
module tb_nk_game_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ng_a, rst_b, ng_b;
  nk_game_engine_if #(.CW(2)) ifa ();
  nk_game_engine_if #(.CW(3)) ifb ();

  logic        illegal_a, busy_a, draw_a, go_a;
  logic [1:0]  cp_a, win_a;
  logic [17:0] board_a;
  logic [8:0]  leds_a;
  logic [3:0]  s1_a, s2_a;
  logic [6:0]  w1_a, w2_a;

  logic        illegal_b, busy_b, draw_b, go_b;
  logic [1:0]  cp_b, win_b;
  logic [49:0] board_b;
  logic [24:0] leds_b;
  logic [0:0]  s1_b, s2_b;
  logic [6:0]  w1_b, w2_b;

  nk_game_engine #(.N(3), .K(3), .SCORE_W(4)) dut_a (
    .clk(clk), .reset(rst_a), .new_game(ng_a), .mv(ifa),
    .illegal(illegal_a), .busy(busy_a), .current_player(cp_a), .board(board_a),
    .leds(leds_a), .winner(win_a), .draw(draw_a), .game_over(go_a),
    .score1(s1_a), .score2(s2_a), .win1(w1_a), .win2(w2_a));

  nk_game_engine #(.N(5), .K(4), .SCORE_W(1)) dut_b (
    .clk(clk), .reset(rst_b), .new_game(ng_b), .mv(ifb),
    .illegal(illegal_b), .busy(busy_b), .current_player(cp_b), .board(board_b),
    .leds(leds_b), .winner(win_b), .draw(draw_b), .game_over(go_b),
    .score1(s1_b), .score2(s2_b), .win1(w1_b), .win2(w2_b));

  int PN[2]    = '{3, 5};
  int PK[2]    = '{3, 4};
  int PCW[2]   = '{2, 3};
  int PSMAX[2] = '{15, 1};

  // Reference model: plain board array plus game bookkeeping.
  int mb[2][8][8];
  int mp[2], mns[2], mmoves[2], mwin[2], ms1[2], ms2[2];
  bit mdraw[2];

  int n_cmp = 0;
  int n_bad = 0;

  logic        o_ill, o_busy, o_draw, o_go, o_ready;
  logic [1:0]  o_cp, o_win;
  logic [49:0] o_board;
  logic [24:0] o_leds;
  logic [3:0]  o_s1, o_s2;
  logic [6:0]  o_w1, o_w2;

  function automatic int run_len(int u, int r, int c, int dr, int dc);
    int n = 0;
    int rr = r + dr;
    int cc = c + dc;
    while (rr >= 0 && rr < PN[u] && cc >= 0 && cc < PN[u] && mb[u][rr][cc] == mp[u]) begin
      n++;
      rr += dr;
      cc += dc;
    end
    return n;
  endfunction

  function automatic bit m_over(int u);
    return (mwin[u] != 0) || mdraw[u];
  endfunction

  task automatic m_move(input int u, input int r, input int c, output bit ill);
    int dirs[4][2] = '{'{0, 1}, '{1, 0}, '{1, 1}, '{1, -1}};
    ill = 1'b0;
    if (m_over(u)) return;
    if (r >= PN[u] || c >= PN[u] || mb[u][r][c] != 0) begin
      ill = 1'b1;
      return;
    end
    mb[u][r][c] = mp[u];
    mmoves[u]++;
    for (int d = 0; d < 4; d++)
      if (1 + run_len(u, r, c, dirs[d][0], dirs[d][1]) + run_len(u, r, c, -dirs[d][0], -dirs[d][1]) >= PK[u])
        mwin[u] = mp[u];
    if (mwin[u] != 0) begin
      if (mp[u] == 1 && ms1[u] < PSMAX[u]) ms1[u]++;
      if (mp[u] == 2 && ms2[u] < PSMAX[u]) ms2[u]++;
    end else if (mmoves[u] == PN[u] * PN[u]) begin
      mdraw[u] = 1'b1;
    end else begin
      mp[u] = 3 - mp[u];
    end
  endtask

  task automatic m_reset(input int u, input bit full);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[u][r][c] = 0;
    mmoves[u] = 0;
    mwin[u]   = 0;
    mdraw[u]  = 1'b0;
    if (full) begin
      ms1[u] = 0; ms2[u] = 0; mp[u] = 1; mns[u] = 2;
    end else begin
      mp[u] = mns[u]; mns[u] = 3 - mns[u];
    end
  endtask

  function automatic logic [49:0] e_board(int u);
    logic [49:0] v = '0;
    for (int r = 0; r < PN[u]; r++)
      for (int c = 0; c < PN[u]; c++) v[2*(r*PN[u]+c) +: 2] = 2'(mb[u][r][c]);
    return v;
  endfunction

  function automatic logic [24:0] e_leds(int u);
    logic [24:0] v = '0;
    for (int r = 0; r < PN[u]; r++)
      for (int c = 0; c < PN[u]; c++) v[r*PN[u]+c] = (mb[u][r][c] != 0);
    return v;
  endfunction

  function automatic logic [6:0] e_w1(int u);
    return (mwin[u] == 1) ? 7'b1001111 : (mdraw[u] ? 7'b1000010 : 7'b1111111);
  endfunction

  function automatic logic [6:0] e_w2(int u);
    return (mwin[u] == 2) ? 7'b0010010 : 7'b1111111;
  endfunction

  task automatic snap(input int u);
    if (u == 0) begin
      o_ill = illegal_a; o_busy = busy_a; o_draw = draw_a; o_go = go_a; o_ready = ifa.move_ready;
      o_cp = cp_a; o_win = win_a; o_board = 50'(board_a); o_leds = 25'(leds_a);
      o_s1 = 4'(s1_a); o_s2 = 4'(s2_a); o_w1 = w1_a; o_w2 = w2_a;
    end else begin
      o_ill = illegal_b; o_busy = busy_b; o_draw = draw_b; o_go = go_b; o_ready = ifb.move_ready;
      o_cp = cp_b; o_win = win_b; o_board = board_b; o_leds = leds_b;
      o_s1 = 4'(s1_b); o_s2 = 4'(s2_b); o_w1 = w1_b; o_w2 = w2_b;
    end
  endtask

  task automatic set_mv(input int u, input bit v, input int r, input int c);
    if (u == 0) begin
      ifa.move_valid = v; ifa.move_row = 2'(r); ifa.move_col = 2'(c);
    end else begin
      ifb.move_valid = v; ifb.move_row = 3'(r); ifb.move_col = 3'(c);
    end
  endtask

  // One-edge reset (full=1) or new_game (full=0); returns at the following negedge.
  task automatic pulse(input int u, input bit full);
    if (u == 0) begin
      if (full) rst_a = 1'b1; else ng_a = 1'b1;
    end else begin
      if (full) rst_b = 1'b1; else ng_b = 1'b1;
    end
    @(negedge clk);
    rst_a = 1'b0; ng_a = 1'b0; rst_b = 1'b0; ng_b = 1'b0;
    m_reset(u, full);
    snap(u);
  endtask

  // Offers one move for a single edge, then waits (bounded) for busy to drop.
  task automatic play(input int u, input int r, input int c, output bit ill, output int bcyc);
    set_mv(u, 1'b1, r, c);
    @(negedge clk);
    set_mv(u, 1'b0, r, c);
    snap(u);
    ill  = o_ill;
    bcyc = 0;
    while (o_busy === 1'b1 && bcyc <= 64) begin
      bcyc++;
      @(negedge clk);
      snap(u);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_timeout u=%0d busy=%b after %0d cycles, want 0", u, o_busy, bcyc);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      pulse(u, 1'b1);
      n_cmp++;
      if ({o_cp, o_win, o_draw, o_go, o_busy, o_ill, o_ready} !== 9'b01_00_0000_1) begin
        n_bad++;
        $display("FAIL reset_ctrl u=%0d got %b want %b", u, {o_cp, o_win, o_draw, o_go, o_busy, o_ill, o_ready}, 9'b01_00_0000_1);
      end
      n_cmp++;
      if ({o_board, o_leds, o_s1, o_s2} !== '0) begin
        n_bad++;
        $display("FAIL reset_board u=%0d board=%h leds=%h s1=%0d s2=%0d want all 0", u, o_board, o_leds, o_s1, o_s2);
      end
      n_cmp++;
      if ({o_w1, o_w2} !== 14'h3fff) begin
        n_bad++;
        $display("FAIL reset_disp u=%0d got %b %b want 1111111 1111111", u, o_w1, o_w2);
      end
    end
  endtask

  task automatic test_p1_win();
    int  rr[5] = '{0, 1, 0, 1, 0};
    int  cc[5] = '{0, 0, 1, 1, 2};
    bit  ill, eill;
    int  bc;
    for (int i = 0; i < 5; i++) begin
      play(0, rr[i], cc[i], ill, bc);
      m_move(0, rr[i], cc[i], eill);
      n_cmp++;
      if (ill !== 1'b0 || bc < 1 || bc > 17) begin
        n_bad++;
        $display("FAIL p1win_move%0d illegal=%b busy_cycles=%0d want 0 and 1..17", i, ill, bc);
      end
    end
    n_cmp++;
    if ({o_win, o_go, o_ready} !== 4'b01_1_0) begin
      n_bad++;
      $display("FAIL p1win_state winner/go/ready got %b want 0110", {o_win, o_go, o_ready});
    end
    n_cmp++;
    if (o_s1 !== 4'd1 || o_s2 !== 4'd0) begin
      n_bad++;
      $display("FAIL p1win_score got %0d/%0d want 1/0", o_s1, o_s2);
    end
    n_cmp++;
    if (o_w1 !== 7'b1001111 || o_w2 !== 7'b1111111) begin
      n_bad++;
      $display("FAIL p1win_disp got %b %b want 1001111 1111111", o_w1, o_w2);
    end
    // A move offered after the game ended must be silently ignored.
    play(0, 2, 2, ill, bc);
    m_move(0, 2, 2, eill);
    n_cmp++;
    if (ill !== 1'b0 || o_board !== e_board(0)) begin
      n_bad++;
      $display("FAIL done_ignore illegal=%b board=%h want 0 board=%h", ill, o_board, e_board(0));
    end
  endtask

  task automatic test_rematch();
    pulse(0, 1'b0);
    n_cmp++;
    if (o_board !== '0 || o_s1 !== 4'd1 || o_cp !== 2'b10 || o_win !== 2'b00) begin
      n_bad++;
      $display("FAIL rematch1 board=%h s1=%0d cp=%b win=%b want 0 1 10 00", o_board, o_s1, o_cp, o_win);
    end
    pulse(0, 1'b0);
    n_cmp++;
    if (o_cp !== 2'b01) begin
      n_bad++;
      $display("FAIL rematch2 cp got %b want 01", o_cp);
    end
  endtask

  task automatic test_illegal();
    int rr[3] = '{1, 1, 3};
    int cc[3] = '{1, 1, 0};
    bit ill, eill;
    int bc;
    for (int i = 0; i < 3; i++) begin
      play(0, rr[i], cc[i], ill, bc);
      m_move(0, rr[i], cc[i], eill);
      n_cmp++;
      if (ill !== (i != 0)) begin
        n_bad++;
        $display("FAIL illegal_pulse%0d got %b want %b", i, ill, (i != 0));
      end
      @(negedge clk);
      snap(0);
      n_cmp++;
      if (o_ill !== 1'b0 || o_board !== e_board(0) || o_cp !== 2'b10) begin
        n_bad++;
        $display("FAIL illegal_after%0d ill=%b board=%h cp=%b want 0 %h 10", i, o_ill, o_board, o_cp, e_board(0));
      end
    end
  endtask

  task automatic test_draw();
    int rr[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int cc[9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    bit ill, eill;
    int bc;
    pulse(0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      play(0, rr[i], cc[i], ill, bc);
      m_move(0, rr[i], cc[i], eill);
    end
    n_cmp++;
    if ({o_draw, o_win, o_go} !== 4'b1_00_1) begin
      n_bad++;
      $display("FAIL draw_state draw/win/go got %b want 1001", {o_draw, o_win, o_go});
    end
    n_cmp++;
    if (o_w1 !== 7'b1000010 || o_w2 !== 7'b1111111 || o_s1 !== 4'd1 || o_s2 !== 4'd0) begin
      n_bad++;
      $display("FAIL draw_disp w1=%b w2=%b s=%0d/%0d want 1000010 1111111 1/0", o_w1, o_w2, o_s1, o_s2);
    end
  endtask

  task automatic test_n5k4();
    int rr[7] = '{0, 0, 1, 1, 3, 2, 2};
    int cc[7] = '{0, 4, 1, 4, 3, 4, 2};
    bit ill, eill;
    int bc;
    for (int i = 0; i < 7; i++) begin
      play(1, rr[i], cc[i], ill, bc);
      m_move(1, rr[i], cc[i], eill);
      n_cmp++;
      if (bc < 1 || bc > 25) begin
        n_bad++;
        $display("FAIL n5k4_busy%0d cycles %0d want 1..25", i, bc);
      end
    end
    n_cmp++;
    if (o_win !== 2'b01 || o_go !== 1'b1 || o_s1 !== 4'd1) begin
      n_bad++;
      $display("FAIL n5k4_win win=%b go=%b s1=%0d want 01 1 1", o_win, o_go, o_s1);
    end
  endtask

  task automatic test_saturation();
    int rr[8] = '{4, 0, 4, 0, 4, 0, 3, 0};
    int cc[8] = '{0, 0, 1, 1, 4, 2, 4, 3};
    bit ill, eill;
    int bc;
    pulse(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      play(1, rr[i], cc[i], ill, bc);
      m_move(1, rr[i], cc[i], eill);
    end
    n_cmp++;
    if (o_win !== 2'b01 || o_s1 !== 4'd1 || o_s2 !== 4'd0) begin
      n_bad++;
      $display("FAIL score_sat win=%b s1=%0d s2=%0d want 01 1 0", o_win, o_s1, o_s2);
    end
  endtask

  task automatic test_reset_mid_check();
    pulse(1, 1'b0);
    set_mv(1, 1'b1, 2, 2);
    @(negedge clk);
    set_mv(1, 1'b0, 0, 0);
    snap(1);
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midcheck_busy got %b want 1", o_busy);
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    m_reset(1, 1'b1);
    snap(1);
    n_cmp++;
    if ({o_busy, o_cp, o_win, o_go} !== 6'b0_01_00_0 || o_board !== '0 || o_leds !== '0 || o_s1 !== 4'd0 || o_w1 !== 7'b1111111) begin
      n_bad++;
      $display("FAIL midcheck_reset busy/cp/win/go=%b board=%h s1=%0d w1=%b want 001000 0 0 1111111",
               {o_busy, o_cp, o_win, o_go}, o_board, o_s1, o_w1);
    end
  endtask

  task automatic test_random();
    bit ill, eill;
    int bc, r, c, att;
    for (int u = 0; u < 2; u++) begin
      for (int g = 0; g < 6; g++) begin
        pulse(u, 1'b0);
        att = 0;
        while (!m_over(u) && att < 150) begin
          att++;
          r = int'($urandom_range(0, (1 << PCW[u]) - 1));
          c = int'($urandom_range(0, (1 << PCW[u]) - 1));
          snap(u);
          n_cmp++;
          if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd_ready u=%0d got %b want 1", u, o_ready);
          end
          play(u, r, c, ill, bc);
          m_move(u, r, c, eill);
          n_cmp++;
          if (ill !== eill || bc > 8 * (PK[u] - 1) + 1 || (!eill && bc == 0)) begin
            n_bad++;
            $display("FAIL rnd_move u=%0d (%0d,%0d) illegal=%b busy=%0d want %b within %0d",
                     u, r, c, ill, bc, eill, 8 * (PK[u] - 1) + 1);
          end
          n_cmp++;
          if (o_board !== e_board(u) || o_leds !== e_leds(u) || o_cp !== 2'(mp[u])) begin
            n_bad++;
            $display("FAIL rnd_board u=%0d board=%h leds=%h cp=%b want %h %h %b",
                     u, o_board, o_leds, o_cp, e_board(u), e_leds(u), 2'(mp[u]));
          end
          n_cmp++;
          if (o_win !== 2'(mwin[u]) || o_draw !== mdraw[u] || o_go !== m_over(u) ||
              o_s1 !== 4'(ms1[u]) || o_s2 !== 4'(ms2[u]) || o_w1 !== e_w1(u) || o_w2 !== e_w2(u)) begin
            n_bad++;
            $display("FAIL rnd_result u=%0d win=%b draw=%b go=%b s=%0d/%0d w=%b/%b want %b %b %b %0d/%0d %b/%b",
                     u, o_win, o_draw, o_go, o_s1, o_s2, o_w1, o_w2, 2'(mwin[u]), mdraw[u], m_over(u),
                     ms1[u], ms2[u], e_w1(u), e_w2(u));
          end
          @(negedge clk);
          snap(u);
          n_cmp++;
          if (o_ill !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_pulse u=%0d illegal still %b want 0", u, o_ill);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b0; ng_a = 1'b0; rst_b = 1'b0; ng_b = 1'b0;
    set_mv(0, 1'b0, 0, 0);
    set_mv(1, 1'b0, 0, 0);
    @(negedge clk);
    test_reset();
    test_p1_win();
    test_rematch();
    test_illegal();
    test_draw();
    test_n5k4();
    test_saturation();
    test_reset_mid_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
